// File: rtl/ps2_kbd_tx_if.sv
// Event handshake and PS/2 line bundle for the ps2_kbd_tx keyboard emulator.
interface ps2_kbd_tx_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_ext;
    logic       ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       byte_done;

    modport master (
        output key_valid, key_code, key_release, key_ext,
        input  ready, ps2_clk, ps2_data, byte_done
    );

    modport slave (
        input  key_valid, key_code, key_release, key_ext,
        output ready, ps2_clk, ps2_data, byte_done
    );
endinterface

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: turns key press/release events into make/break frames.
// Define PS2_TX_EXT_EN to prepend E0 for extended keys (key_ext=1 at accept).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | lines high, ready=1, waiting for key_valid
// S_LOAD   | one cycle: pick current byte, build 11-bit frame
// S_BIT_HI | ps2_clk high half of a bit, data already on the line
// S_BIT_LO | ps2_clk low half of a bit, host samples on the falling edge
// S_GAP    | inter-frame idle, then next byte or back to idle
module ps2_kbd_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic         clk,
    input  logic         rst,
    ps2_kbd_tx_if.slave  bus
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);

`ifdef PS2_TX_EXT_EN
    localparam int IW = 2;
`else
    localparam int IW = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [CW-1:0]   r_cnt,      w_cnt_nxt;
    logic [3:0]      r_bit_idx,  w_bit_idx_nxt;
    logic [9:0]      r_shift,    w_shift_nxt;
    logic [IW-1:0]   r_byte_idx, w_byte_idx_nxt;
    logic [IW-1:0]   r_last_idx, w_last_idx_nxt;
    logic [7:0]      r_code,     w_code_nxt;
    logic            r_release,  w_release_nxt;
    logic            r_ready,    w_ready_nxt;
    logic            r_ps2_clk,  w_clk_nxt;
    logic            r_ps2_data, w_data_nxt;
    logic            r_byte_done, w_byte_done_nxt;
    logic [7:0]      w_cur_byte;
    logic [10:0]     w_frame;

`ifdef PS2_TX_EXT_EN
    logic            r_ext, w_ext_nxt;
`else
    logic            w_unused_ext;
    assign w_unused_ext = bus.key_ext;
`endif

    // Byte order per event: [E0] [F0] code
    always_comb begin
        w_cur_byte = r_code;
`ifdef PS2_TX_EXT_EN
        if (r_ext) begin
            case (r_byte_idx)
                2'd0:    w_cur_byte = 8'hE0;
                2'd1:    w_cur_byte = r_release ? 8'hF0 : r_code;
                default: w_cur_byte = r_code;
            endcase
        end else if (r_release && (r_byte_idx == 2'd0)) begin
            w_cur_byte = 8'hF0;
        end
`else
        if (r_release && (r_byte_idx == 1'b0)) begin
            w_cur_byte = 8'hF0;
        end
`endif
    end

    assign w_frame = {1'b1, ~^w_cur_byte, w_cur_byte, 1'b0};

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_byte_idx_nxt  = r_byte_idx;
        w_last_idx_nxt  = r_last_idx;
        w_code_nxt      = r_code;
        w_release_nxt   = r_release;
        w_data_nxt      = r_ps2_data;
        w_byte_done_nxt = 1'b0;
`ifdef PS2_TX_EXT_EN
        w_ext_nxt       = r_ext;
`endif

        unique case (r_state)
            S_IDLE: begin
                if (bus.key_valid && r_ready) begin
                    w_code_nxt     = bus.key_code;
                    w_release_nxt  = bus.key_release;
                    w_byte_idx_nxt = '0;
`ifdef PS2_TX_EXT_EN
                    w_ext_nxt      = bus.key_ext;
                    w_last_idx_nxt = {bus.key_ext & bus.key_release,
                                      bus.key_ext ^ bus.key_release};
`else
                    w_last_idx_nxt = bus.key_release;
`endif
                    w_state_nxt    = S_LOAD;
                end
            end

            S_LOAD: begin
                w_shift_nxt   = w_frame[10:1];
                w_data_nxt    = w_frame[0];
                w_bit_idx_nxt = '0;
                w_cnt_nxt     = HALF_LOAD;
                w_state_nxt   = S_BIT_HI;
            end

            S_BIT_HI: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = HALF_LOAD;
                    w_state_nxt = S_BIT_LO;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            S_BIT_LO: begin
                if (r_cnt == '0) begin
                    if (r_bit_idx == 4'd10) begin
                        w_data_nxt      = 1'b1;
                        w_byte_done_nxt = 1'b1;
                        w_cnt_nxt       = GAP_LOAD;
                        w_state_nxt     = S_GAP;
                    end else begin
                        // Data moves only here, while the clock is going high
                        w_data_nxt    = r_shift[0];
                        w_shift_nxt   = {1'b1, r_shift[9:1]};
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                        w_cnt_nxt     = HALF_LOAD;
                        w_state_nxt   = S_BIT_HI;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            S_GAP: begin
                if (r_cnt == '0) begin
                    if (r_byte_idx == r_last_idx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + IW'(1);
                        w_state_nxt    = S_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_clk_nxt   = (w_state_nxt != S_BIT_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_last_idx  <= '0;
            r_code      <= '0;
            r_release   <= 1'b0;
            r_ready     <= 1'b1;
            r_ps2_clk   <= 1'b1;
            r_ps2_data  <= 1'b1;
            r_byte_done <= 1'b0;
`ifdef PS2_TX_EXT_EN
            r_ext       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_last_idx  <= w_last_idx_nxt;
            r_code      <= w_code_nxt;
            r_release   <= w_release_nxt;
            r_ready     <= w_ready_nxt;
            r_ps2_clk   <= w_clk_nxt;
            r_ps2_data  <= w_data_nxt;
            r_byte_done <= w_byte_done_nxt;
`ifdef PS2_TX_EXT_EN
            r_ext       <= w_ext_nxt;
`endif
        end
    end

    assign bus.ready     = r_ready;
    assign bus.ps2_clk   = r_ps2_clk;
    assign bus.ps2_data  = r_ps2_data;
    assign bus.byte_done = r_byte_done;

endmodule
